sram_ctrl: RTL and testbench

- Memory-mapped bridge between the SoC data bus and the off-chip 1M x 16 asynchronous SRAM pins.
- Converts one 32-bit word request into up to two sequenced 16-bit SRAM phases, low half first, then high half.
- Handles byte-lane masking and read-data assembly.
- Sits directly upstream of the SRAM_* pins of the SoC top. The top instantiates the DQ tristate from sram_dq_o/sram_dq_oe/sram_dq_i.

---
 rtl/sram_ctrl_pkg.sv | 32 +++
 rtl/sram_phase_timer.sv | 59 +++++
 rtl/sram_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_sram_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and widths for the 32-bit bus to 16-bit async SRAM bridge.
package sram_ctrl_pkg;

    localparam int unsigned SRAM_DW = 16;
    localparam int unsigned BUS_DW  = 32;
    localparam int unsigned STRB_W  = BUS_DW / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PH_LO = 2'd1,
        PH_HI = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SETUP  = 2'd0,
        STROBE = 2'd1,
        HOLD   = 2'd2
    } phase_t;

    // Request fields latched at accept; the address is kept separately at SRAM width.
    typedef struct packed {
        logic              we;
        logic [BUS_DW-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } txn_t;

    function automatic logic is_phase(input state_t s);
        return (s == PH_LO) || (s == PH_HI);
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Sequences SETUP / STROBE x WAIT_CYCLES / HOLD within one SRAM phase.
module sram_phase_timer
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    output logic [1:0] phase_nxt_o,
    output logic       phase_done_o,
    output logic       capture_o
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    phase_t             phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               strobe_last;

    assign strobe_last = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            phase_d = SETUP;
            cnt_d   = '0;
        end else begin
            case (phase_q)
                SETUP: begin
                    phase_d = STROBE;
                    cnt_d   = '0;
                end
                STROBE: begin
                    if (strobe_last) phase_d = HOLD;
                    else             cnt_d   = cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // HOLD doubles as the parked state between phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= HOLD;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    assign phase_nxt_o  = phase_d;
    assign phase_done_o = (phase_q == HOLD);
    assign capture_o    = (phase_q == STROBE) && strobe_last;

endmodule

// File: rtl/sram_ctrl.sv
// Bridges one 32-bit bus request into up to two 16-bit async SRAM phases, low half first.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned SRAM_AW     = 20
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [3:0]         req_wstrb,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_UB_N,
    output logic [15:0]        sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_i
);

    localparam int unsigned WADDR_W = SRAM_AW - 1;

    state_t               state_q, state_d;
    txn_t                 txn_q, txn_d;
    logic [WADDR_W-1:0]   waddr_q, waddr_d;
    logic [BUS_DW-1:0]    rbuf_q, rbuf_d;

    logic                 req_ready_q, req_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [BUS_DW-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic [SRAM_AW-1:0]   addr_q, addr_d;
    logic                 ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic                 lb_n_q, lb_n_d, ub_n_q, ub_n_d;
    logic [SRAM_DW-1:0]   dq_q, dq_d;
    logic                 dq_oe_q, dq_oe_d;

    logic                 accept;
    logic                 start;
    logic [1:0]           phase_nxt_raw;
    phase_t               phase_nxt;
    logic                 phase_done;
    logic                 capture;
    logic                 in_phase, hi, strobe;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:SRAM_AW+1]};
    assign accept           = req_valid && req_ready_q;
    assign start            = is_phase(state_d) && (state_d != state_q);
    assign phase_nxt        = phase_t'(phase_nxt_raw);

    sram_phase_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk          (ACLK),
        .rst_n        (ARESETN),
        .start_i      (start),
        .phase_nxt_o  (phase_nxt_raw),
        .phase_done_o (phase_done),
        .capture_o    (capture)
    );

    // Phase sequencing; writes skip halves whose byte enables are all clear.
    always_comb begin
        state_d = state_q;
        txn_d   = txn_q;
        waddr_d = waddr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    txn_d   = '{we: req_we, wdata: req_wdata, wstrb: req_wstrb};
                    waddr_d = req_addr[SRAM_AW:2];
                    if (!req_we || (req_wstrb[1:0] != 2'b00)) state_d = PH_LO;
                    else if (req_wstrb[3:2] != 2'b00)         state_d = PH_HI;
                    else                                      state_d = RESP;
                end
            end
            PH_LO: begin
                if (phase_done)
                    state_d = (!txn_q.we || (txn_q.wstrb[3:2] != 2'b00)) ? PH_HI : RESP;
            end
            PH_HI: begin
                if (phase_done) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin values are derived from the next state so every output comes straight from a flop.
    always_comb begin
        in_phase    = is_phase(state_d);
        hi          = (state_d == PH_HI);
        strobe      = in_phase && (phase_nxt == STROBE);
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        rsp_rdata_d = rsp_rdata_q;
        ce_n_d      = !in_phase;
        oe_n_d      = !(strobe && !txn_d.we);
        we_n_d      = !(strobe && txn_d.we);
        dq_oe_d     = in_phase && txn_d.we;
        addr_d      = addr_q;
        dq_d        = dq_q;
        lb_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        rbuf_d      = rbuf_q;

        if ((state_d == RESP) && !txn_d.we) rsp_rdata_d = rbuf_q;

        if (in_phase) begin
            addr_d = {waddr_d, hi};
            if (txn_d.we) begin
                lb_n_d = hi ? ~txn_d.wstrb[2] : ~txn_d.wstrb[0];
                ub_n_d = hi ? ~txn_d.wstrb[3] : ~txn_d.wstrb[1];
                dq_d   = hi ? txn_d.wdata[31:16] : txn_d.wdata[15:0];
            end else begin
                lb_n_d = 1'b0;
                ub_n_d = 1'b0;
            end
        end

        if (capture && !txn_q.we) begin
            if (state_q == PH_LO)      rbuf_d[15:0]  = sram_dq_i;
            else if (state_q == PH_HI) rbuf_d[31:16] = sram_dq_i;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            txn_q       <= '0;
            waddr_q     <= '0;
            rbuf_q      <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            dq_q        <= '0;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            txn_q       <= txn_d;
            waddr_q     <= waddr_d;
            rbuf_q      <= rbuf_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_q      <= addr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            lb_n_q      <= lb_n_d;
            ub_n_q      <= ub_n_d;
            dq_q        <= dq_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign SRAM_ADDR  = addr_q;
    assign SRAM_CE_N  = ce_n_q;
    assign SRAM_OE_N  = oe_n_q;
    assign SRAM_WE_N  = we_n_q;
    assign SRAM_LB_N  = lb_n_q;
    assign SRAM_UB_N  = ub_n_q;
    assign sram_dq_o  = dq_q;
    assign sram_dq_oe = dq_oe_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (WAIT_CYCLES 1 and 3) on behavioural SRAM pin models.
module tb_sram_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic [19:0] sram_addr [2];
    logic        ce_n [2], oe_n [2], we_n [2], lb_n [2], ub_n [2];
    logic [15:0] dq_o [2];
    logic        dq_oe [2];
    logic [15:0] dq_i [2];

    int n_checks = 0;
    int n_fail   = 0;
    int viol     = 0;
    logic [31:0] last_rd = 32'h0;

    logic [15:0] sram_mem [bit [20:0]];
    logic [31:0] ref_mem  [int unsigned];

    logic        tr_ce [64], tr_oe [64], tr_we [64], tr_lb [64], tr_ub [64], tr_dqoe [64];
    logic [19:0] tr_addr [64];
    logic [15:0] tr_dq [64];

    always #5 ACLK = ~ACLK;

    sram_ctrl #(.WAIT_CYCLES(1), .SRAM_AW(20)) dut_w1 (
        .ACLK(ACLK), .ARESETN(ARESETN), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .SRAM_ADDR(sram_addr[0]),
        .SRAM_CE_N(ce_n[0]), .SRAM_OE_N(oe_n[0]), .SRAM_WE_N(we_n[0]), .SRAM_LB_N(lb_n[0]),
        .SRAM_UB_N(ub_n[0]), .sram_dq_o(dq_o[0]), .sram_dq_oe(dq_oe[0]), .sram_dq_i(dq_i[0])
    );

    sram_ctrl #(.WAIT_CYCLES(3), .SRAM_AW(20)) dut_w3 (
        .ACLK(ACLK), .ARESETN(ARESETN), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .SRAM_ADDR(sram_addr[1]),
        .SRAM_CE_N(ce_n[1]), .SRAM_OE_N(oe_n[1]), .SRAM_WE_N(we_n[1]), .SRAM_LB_N(lb_n[1]),
        .SRAM_UB_N(ub_n[1]), .sram_dq_o(dq_o[1]), .sram_dq_oe(dq_oe[1]), .sram_dq_i(dq_i[1])
    );

    // Async SRAM pin model plus protocol invariant monitor, one per instance.
    always @(negedge ACLK) begin
        bit [20:0]   key;
        logic [15:0] cur;
        for (int i = 0; i < 2; i++) begin
            key = {i[0], sram_addr[i]};
            if (!ce_n[i] && !we_n[i]) begin
                if (!dq_oe[i]) viol++;
                cur = sram_mem.exists(key) ? sram_mem[key] : 16'h0;
                if (!lb_n[i]) cur[7:0]  = dq_o[i][7:0];
                if (!ub_n[i]) cur[15:8] = dq_o[i][15:8];
                sram_mem[key] = cur;
            end
            if (!ce_n[i] && !oe_n[i]) dq_i[i] = sram_mem.exists(key) ? sram_mem[key] : 16'h0;
            else                      dq_i[i] = 16'($urandom);
            if (!oe_n[i] && !we_n[i]) viol++;
            if (!oe_n[i] && dq_oe[i]) viol++;
        end
    end

    function automatic int unsigned ref_key(input int d, input logic [31:0] a);
        return (32'(d) << 20) | 32'(a[20:2]);
    endfunction

    function automatic logic [31:0] ref_read(input int d, input logic [31:0] a);
        int unsigned k = ref_key(d, a);
        return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    endfunction

    function automatic void ref_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                                      input logic [3:0] st);
        logic [31:0] w = ref_read(d, a);
        for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
        ref_mem[ref_key(d, a)] = w;
    endfunction

    // Cycle of rsp_valid after the accept edge: one per skipped-to-RESP, WAIT+2 per phase.
    function automatic int exp_latency(input logic we, input logic [3:0] st, input int wc);
        int ph = we ? (int'(|st[1:0]) + int'(|st[3:2])) : 2;
        return ph * (wc + 2) + 1;
    endfunction

    task automatic start_txn(input int d, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] st, output bit ok);
        int guard = 0;
        @(negedge ACLK);
        req_we = we; req_addr = a; req_wdata = wd; req_wstrb = st;
        req_valid[d] = 1'b1;
        while (!req_ready[d] && guard < 50) begin
            @(negedge ACLK);
            guard++;
        end
        ok = req_ready[d];
        @(posedge ACLK); #1;
        req_valid[d] = 1'b0;
    endtask

    // Issues one request and records pin state per cycle (index 1 = cycle after accept).
    task automatic run_txn(input int d, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] st,
                           output int rsp_cyc, output logic [31:0] rd);
        bit ok;
        rsp_cyc = 0;
        rd = 32'h0;
        for (int k = 0; k < 64; k++) begin
            tr_ce[k] = 1'b1; tr_oe[k] = 1'b1; tr_we[k] = 1'b1; tr_lb[k] = 1'b1;
            tr_ub[k] = 1'b1; tr_dqoe[k] = 1'b0; tr_addr[k] = '0; tr_dq[k] = '0;
        end
        start_txn(d, we, a, wd, st, ok);
        if (ok) begin
            for (int k = 1; k < 64; k++) begin
                tr_ce[k] = ce_n[d]; tr_oe[k] = oe_n[d]; tr_we[k] = we_n[d];
                tr_lb[k] = lb_n[d]; tr_ub[k] = ub_n[d]; tr_dqoe[k] = dq_oe[d];
                tr_addr[k] = sram_addr[d]; tr_dq[k] = dq_o[d];
                if (rsp_valid[d]) begin
                    rsp_cyc = k;
                    rd = rsp_rdata[d];
                    break;
                end
                @(posedge ACLK); #1;
            end
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b1;
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        #3 ARESETN = 1'b0;
        repeat (10) @(posedge ACLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({ce_n[d], oe_n[d], we_n[d], lb_n[d], ub_n[d], dq_oe[d], req_ready[d], rsp_valid[d]} !== 8'b11111000) begin
                n_fail++;
                $display("FAIL reset_ctrl[%0d]: got %b expected 11111000", d,
                         {ce_n[d], oe_n[d], we_n[d], lb_n[d], ub_n[d], dq_oe[d], req_ready[d], rsp_valid[d]});
            end
            n_checks++;
            if ({sram_addr[d], dq_o[d], rsp_rdata[d]} !== 68'h0) begin
                n_fail++;
                $display("FAIL reset_data[%0d]: addr %h dq %h rdata %h expected zeros", d,
                         sram_addr[d], dq_o[d], rsp_rdata[d]);
            end
        end
        @(negedge ACLK) ARESETN = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({ce_n[d], oe_n[d], we_n[d], lb_n[d], ub_n[d], dq_oe[d], req_ready[d], rsp_valid[d]} !== 8'b11111010) begin
                n_fail++;
                $display("FAIL idle_ctrl[%0d]: got %b expected 11111010", d,
                         {ce_n[d], oe_n[d], we_n[d], lb_n[d], ub_n[d], dq_oe[d], req_ready[d], rsp_valid[d]});
            end
        end
    endtask

    task automatic test_full_write_read();
        int cyc;
        logic [31:0] rd;
        logic [5:0] we_mask, oe_mask, dqoe_mask, lane_mask;
        run_txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, cyc, rd);
        ref_write(0, 32'h10, 32'hDEAD_BEEF, 4'hF);
        for (int k = 1; k <= 6; k++) begin
            we_mask[k-1] = !tr_we[k];
            dqoe_mask[k-1] = tr_dqoe[k];
        end
        n_checks++;
        if (cyc !== 7) begin n_fail++; $display("FAIL full_write_latency: got %0d expected 7", cyc); end
        n_checks++;
        if ({tr_addr[1], tr_addr[4]} !== {20'h00008, 20'h00009}) begin
            n_fail++; $display("FAIL full_write_addr: got %h/%h expected 00008/00009", tr_addr[1], tr_addr[4]);
        end
        n_checks++;
        if ({tr_dq[2], tr_dq[5]} !== 32'hBEEF_DEAD) begin
            n_fail++; $display("FAIL full_write_dq: got %h/%h expected beef/dead", tr_dq[2], tr_dq[5]);
        end
        n_checks++;
        if (we_mask !== 6'b010010) begin n_fail++; $display("FAIL full_write_we_n: got %b expected 010010", we_mask); end
        n_checks++;
        if (dqoe_mask !== 6'b111111) begin n_fail++; $display("FAIL full_write_dq_oe: got %b expected 111111", dqoe_mask); end
        n_checks++;
        if ({tr_ce[1], tr_oe[1], tr_we[1], tr_lb[2], tr_ub[2]} !== 5'b01100) begin
            n_fail++; $display("FAIL full_write_setup_lanes: got %b expected 01100",
                               {tr_ce[1], tr_oe[1], tr_we[1], tr_lb[2], tr_ub[2]});
        end

        run_txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, cyc, rd);
        for (int k = 1; k <= 6; k++) begin
            oe_mask[k-1] = !tr_oe[k];
            dqoe_mask[k-1] = tr_dqoe[k];
            lane_mask[k-1] = !tr_lb[k] && !tr_ub[k];
        end
        n_checks++;
        if (cyc !== 7) begin n_fail++; $display("FAIL full_read_latency: got %0d expected 7", cyc); end
        n_checks++;
        if (rd !== ref_read(0, 32'h10)) begin
            n_fail++; $display("FAIL full_read_data: got %h expected %h", rd, ref_read(0, 32'h10));
        end
        n_checks++;
        if ({oe_mask, dqoe_mask, lane_mask} !== {6'b010010, 6'b000000, 6'b111111}) begin
            n_fail++; $display("FAIL full_read_pins: oe %b dq_oe %b lanes %b expected 010010/000000/111111",
                               oe_mask, dqoe_mask, lane_mask);
        end
        last_rd = ref_read(0, 32'h10);
    endtask

    task automatic test_byte_write();
        int cyc;
        logic [31:0] rd;
        run_txn(0, 1'b1, 32'h0000_0010, 32'h00AA_0000, 4'h4, cyc, rd);
        ref_write(0, 32'h10, 32'h00AA_0000, 4'h4);
        n_checks++;
        if (cyc !== 4) begin n_fail++; $display("FAIL byte_write_latency: got %0d expected 4", cyc); end
        n_checks++;
        if ({tr_addr[1], tr_lb[2], tr_ub[2], tr_dq[2]} !== {20'h00009, 1'b0, 1'b1, 16'h00AA}) begin
            n_fail++; $display("FAIL byte_write_pins: addr %h lb %b ub %b dq %h expected 00009 0 1 00aa",
                               tr_addr[1], tr_lb[2], tr_ub[2], tr_dq[2]);
        end
        n_checks++;
        if (rd !== last_rd) begin n_fail++; $display("FAIL write_keeps_rdata: got %h expected %h", rd, last_rd); end
        run_txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, cyc, rd);
        n_checks++;
        if ((rd !== ref_read(0, 32'h10)) || (rd !== 32'hDEAA_BEEF)) begin
            n_fail++; $display("FAIL byte_readback: got %h expected deaabeef", rd);
        end
        last_rd = rd;
    endtask

    task automatic test_zero_strobe();
        int cyc;
        logic [31:0] rd;
        run_txn(0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, cyc, rd);
        n_checks++;
        if ({cyc, tr_ce[1]} !== {32'd1, 1'b1}) begin
            n_fail++; $display("FAIL zero_strobe: rsp cycle %0d ce_n %b expected 1 1", cyc, tr_ce[1]);
        end
        @(posedge ACLK); #1;
        n_checks++;
        if ({rsp_valid[0], req_ready[0]} !== 2'b01) begin
            n_fail++; $display("FAIL rsp_single_pulse: rsp_valid %b req_ready %b expected 0 1", rsp_valid[0], req_ready[0]);
        end
    endtask

    task automatic test_reset_mid_access();
        bit ok;
        int pulses = 0;
        int cyc;
        logic [31:0] rd;
        start_txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, ok);
        repeat (4) begin @(posedge ACLK); #1; end
        n_checks++;
        if ({ok, oe_n[0], sram_addr[0]} !== {1'b1, 1'b0, 20'h00009}) begin
            n_fail++; $display("FAIL mid_reset_setup: accepted %b oe_n %b addr %h expected 1 0 00009", ok, oe_n[0], sram_addr[0]);
        end
        ARESETN = 1'b0;
        #1;
        n_checks++;
        if ({ce_n[0], oe_n[0], we_n[0], lb_n[0], ub_n[0], dq_oe[0], rsp_valid[0]} !== 7'b1111100) begin
            n_fail++; $display("FAIL mid_reset_idle: got %b expected 1111100",
                               {ce_n[0], oe_n[0], we_n[0], lb_n[0], ub_n[0], dq_oe[0], rsp_valid[0]});
        end
        repeat (3) begin @(posedge ACLK); #1; if (rsp_valid[0]) pulses++; end
        @(negedge ACLK) ARESETN = 1'b1;
        repeat (12) begin @(posedge ACLK); #1; if (rsp_valid[0]) pulses++; end
        n_checks++;
        if (pulses !== 0) begin n_fail++; $display("FAIL mid_reset_no_rsp: got %0d pulses expected 0", pulses); end
        run_txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, cyc, rd);
        n_checks++;
        if ({cyc, rd} !== {32'd7, ref_read(0, 32'h10)}) begin
            n_fail++; $display("FAIL post_reset_read: cycle %0d data %h expected 7 %h", cyc, rd, ref_read(0, 32'h10));
        end
        last_rd = rd;
    endtask

    task automatic test_random();
        int cyc;
        logic [31:0] rd, a, wd;
        logic [3:0] st;
        logic we;
        for (int n = 0; n < 24; n++) begin
            we = 1'($urandom_range(0, 1));
            a  = ($urandom & 32'hFFE0_0003) | (32'h100 + 32'(4 * $urandom_range(0, 7)));
            wd = $urandom;
            st = 4'($urandom);
            run_txn(0, we, a, wd, st, cyc, rd);
            n_checks++;
            if (cyc !== exp_latency(we, st, 1)) begin
                n_fail++; $display("FAIL rand_latency[%0d]: we %b strb %h got %0d expected %0d", n, we, st, cyc, exp_latency(we, st, 1));
            end
            if (we) begin
                n_checks++;
                if (rd !== last_rd) begin n_fail++; $display("FAIL rand_write_rdata[%0d]: got %h expected %h", n, rd, last_rd); end
                if (st != 4'h0) begin
                    n_checks++;
                    if (tr_addr[1] !== {a[20:2], (st[1:0] == 2'b00)}) begin
                        n_fail++; $display("FAIL rand_write_addr[%0d]: got %h expected %h", n, tr_addr[1], {a[20:2], (st[1:0] == 2'b00)});
                    end
                end
                ref_write(0, a, wd, st);
            end else begin
                n_checks++;
                if (rd !== ref_read(0, a)) begin n_fail++; $display("FAIL rand_read[%0d]: got %h expected %h", n, rd, ref_read(0, a)); end
                last_rd = ref_read(0, a);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, guard, rdy_first, rsp1, rsp2, oe_ph, oe_tot;
        logic [31:0] rd, rd1, rd2;
        logic [31:0] a1 = 32'h0000_2040;
        logic [31:0] a2 = 32'h0000_2044;
        run_txn(1, 1'b1, a1, $urandom, 4'hF, cyc, rd);
        ref_write(1, a1, req_wdata, 4'hF);
        n_checks++;
        if (cyc !== exp_latency(1'b1, 4'hF, 3)) begin n_fail++; $display("FAIL w3_write_latency: got %0d expected 11", cyc); end
        run_txn(1, 1'b1, a2, $urandom, 4'hF, cyc, rd);
        ref_write(1, a2, req_wdata, 4'hF);

        @(negedge ACLK);
        req_we = 1'b0; req_addr = a1; req_valid[1] = 1'b1;
        guard = 0;
        while (!req_ready[1] && guard < 50) begin @(negedge ACLK); guard++; end
        @(posedge ACLK); #1;
        req_addr = a2;
        rdy_first = 0; rsp1 = 0; rsp2 = 0; oe_ph = 0; oe_tot = 0; rd1 = '0; rd2 = '0;
        for (int k = 1; k <= 30; k++) begin
            if (!oe_n[1] && k <= 5) oe_ph++;
            if (!oe_n[1] && k <= 11) oe_tot++;
            if (req_ready[1] && rdy_first == 0) rdy_first = k;
            if (rsp_valid[1]) begin
                if (rsp1 == 0) begin rsp1 = k; rd1 = rsp_rdata[1]; end
                else if (rsp2 == 0) begin rsp2 = k; rd2 = rsp_rdata[1]; end
            end
            if (rdy_first != 0 && k == rdy_first + 1) req_valid[1] = 1'b0;
            @(posedge ACLK); #1;
        end
        req_valid[1] = 1'b0;
        n_checks++;
        if ({oe_ph, oe_tot} !== {32'd3, 32'd6}) begin
            n_fail++; $display("FAIL w3_oe_cycles: phase %0d total %0d expected 3 6", oe_ph, oe_tot);
        end
        n_checks++;
        if ({rsp1, rdy_first, rsp2} !== {32'd11, 32'd12, 32'd23}) begin
            n_fail++; $display("FAIL w3_b2b_timing: rsp1 %0d ready %0d rsp2 %0d expected 11 12 23", rsp1, rdy_first, rsp2);
        end
        n_checks++;
        if ({rd1, rd2} !== {ref_read(1, a1), ref_read(1, a2)}) begin
            n_fail++; $display("FAIL w3_b2b_data: got %h/%h expected %h/%h", rd1, rd2, ref_read(1, a1), ref_read(1, a2));
        end
        n_checks++;
        if (viol !== 0) begin n_fail++; $display("FAIL pin_invariants: got %0d violations expected 0", viol); end
    endtask

    initial begin
        test_reset();
        test_full_write_read();
        test_byte_write();
        test_zero_strobe();
        test_reset_mid_access();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
